mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ALIGN_CHECK, default 1, meaning: 1 = reject accesses with addr[1:0] != 0; 0 = pass every address to memory.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 i_req  input  1  instruction-fetch request (read-only port I).
REQ-005 i_addr  input  32  fetch byte address.
REQ-006 i_ack  output  1  one-cycle completion strobe for port I.
REQ-007 i_rdata  output  32  fetch read data, valid when i_ack=1.
REQ-008 i_err  output  1  misalignment error, valid when i_ack=1.
REQ-009 d_req  input  1  data request (port D).
REQ-010 d_we  input  1  1 = write, 0 = read.
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  32  write data.
REQ-013 d_ack  output  1  one-cycle completion strobe for port D.
REQ-014 d_rdata  output  32  data read result, valid when d_ack=1 and the access was a read.
REQ-015 d_err  output  1  misalignment error, valid when d_ack=1.
REQ-016 mem_cs, mem_oe, mem_we  output  1 each  synchronous RAM chip select, output enable and write enable.
REQ-017 mem_addr, mem_din  output  32 each  RAM address and write data.
REQ-018 mem_dout  input  32  RAM read data; updated by the RAM on the rising edge at which cs=1 and oe=1.

Function
REQ-019 FSM states: IDLE, ISSUE, DONE; encoded in a register; all outputs are decoded from registered state only.
REQ-020 IDLE: at a rising edge with any req=1, latch owner, addr, we (I is always read) and wdata, then go to ISSUE. With no req, stay in IDLE.
REQ-021 Arbitration is round-robin: if only one req=1, grant that port. If both req=1, grant the port that is not last_grant. last_grant updates on every grant.
REQ-022 ISSUE lasts exactly 1 cycle: mem_cs=1, mem_we=latched we, mem_oe=~latched we, mem_addr/mem_din = latched values; next state is DONE.
REQ-023 When ALIGN_CHECK=1 and latched addr[1:0]!=0: ISSUE drives mem_cs=mem_oe=mem_we=0 (no RAM access), and DONE asserts the owner's err=1.
REQ-024 DONE lasts exactly 1 cycle: owner's ack=1; owner's rdata=mem_dout for a successful read, otherwise 0; next state is IDLE.
REQ-025 Latency: ack is asserted in the second cycle after the edge at which req was sampled. Throughput: one transaction per 3 cycles.
REQ-026 Requesters hold req, addr, we and wdata stable until they sample ack=1, and drop req on that same edge. A req still high in IDLE starts a new transaction.
REQ-027 Changes to inputs during ISSUE or DONE have no effect on the transaction in flight.
REQ-028 Outside DONE, all ack, err and rdata outputs are 0. Outside ISSUE, mem_cs, mem_oe and mem_we are 0, and mem_addr and mem_din are 0.
REQ-029 The non-owning port never sees ack, err or non-zero rdata.

Reset
REQ-030 rst_n=0 immediately (asynchronously) forces: state=IDLE, last_grant=I, all outputs 0, latched registers 0.
REQ-031 Reset during ISSUE or DONE aborts the transaction: no ack is ever issued for it. After rst_n returns to 1, arbitration restarts from IDLE with D winning the first tie.

Verification
REQ-032 Single read: RAM holds 0x00000004=0xDEADBEEF; i_req=1, i_addr=0x4 sampled at edge N. Required: ISSUE at N+1 with mem_cs=1, mem_oe=1; i_ack=1 and i_rdata=0xDEADBEEF in the DONE cycle; d_ack=0 throughout.
REQ-033 Write then read: D writes 0x8 <- 0x12345678, then D reads 0x8. Required: write ISSUE has mem_we=1, mem_oe=0, mem_din=0x12345678 and d_rdata=0 at its ack; the read returns d_rdata=0x12345678.
REQ-034 Contention: i_req and d_req both held high from reset release, each port dropping req on its ack edge and re-raising it in the next cycle. Required: grant order D, I, D, I; exactly one ack per 3 cycles; acks never overlap.
REQ-035 Misalignment: d_req with d_addr=0x6 and ALIGN_CHECK=1. Required: mem_cs stays 0 for the whole transaction; DONE has d_ack=1, d_err=1, d_rdata=0. Repeat with ALIGN_CHECK=0: the RAM access occurs and d_err=0.
REQ-036 Reset mid-operation: assert rst_n=0 between clock edges during ISSUE. Required: all outputs go to 0 before the next edge; no ack is issued; after release, a tie is granted to D.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one synchronous RAM between an
// instruction-fetch port (I, read-only) and a data port (D, read/write).
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   i_req/i_addr                      fetch request and byte address
//   i_ack/i_rdata/i_err               fetch completion strobe, read data, misalignment error
//   d_req/d_we/d_addr/d_wdata         data request, write enable, byte address, write data
//   d_ack/d_rdata/d_err               data completion strobe, read data, misalignment error
//   mem_cs/mem_oe/mem_we              RAM chip select, output enable, write enable
//   mem_addr/mem_din                  RAM address and write data
//   mem_dout                          RAM read data (registered inside the RAM)
//
// Each transaction is IDLE -> ISSUE -> DONE; every output is decoded from
// registered state, so the request inputs never reach the outputs combinationally.
module mem_arbiter #(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    output logic        i_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        mem_cs,
    output logic        mem_oe,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        start, grant, mis, issue, done;
    logic [31:0] rd;

    // Owner and last_grant encoding: 0 = port I, 1 = port D.
    // On a tie the port that did not win last time is granted.
    assign start = (state_q == IDLE) && (i_req || d_req);
    assign grant = (i_req && d_req) ? ~last_q : d_req;

    always_comb begin
        state_d = (state_q == IDLE) ? (start ? ISSUE : IDLE) :
                  (state_q == ISSUE) ? DONE : IDLE;
        owner_d = start ? grant : owner_q;
        last_d  = start ? grant : last_q;
        we_d    = start ? (grant & d_we) : we_q;
        addr_d  = start ? (grant ? d_addr : i_addr) : addr_q;
        wdata_d = start ? (grant ? d_wdata : 32'd0) : wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mis   = ALIGN_CHECK && (addr_q[1:0] != 2'b00);
    assign issue = (state_q == ISSUE);
    assign done  = (state_q == DONE);

    // A misaligned access is suppressed at the RAM but still completes with err.
    assign mem_cs   = issue & ~mis;
    assign mem_oe   = mem_cs & ~we_q;
    assign mem_we   = mem_cs & we_q;
    assign mem_addr = issue ? addr_q : 32'd0;
    assign mem_din  = issue ? wdata_q : 32'd0;

    assign rd = (done && !we_q && !mis) ? mem_dout : 32'd0;

    assign i_ack   = done & ~owner_q;
    assign i_err   = i_ack & mis;
    assign i_rdata = owner_q ? 32'd0 : rd;
    assign d_ack   = done & owner_q;
    assign d_err   = d_ack & mis;
    assign d_rdata = owner_q ? rd : 32'd0;
endmodule
